// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB responder: FSM state encoding, device-ID byte
// derivation and bit-counter sizing.
package sccb_pkg;

    localparam int unsigned BIT_CNT_W = 3;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = '1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ID_X,
        ST_SUB,
        ST_SUB_X,
        ST_WDATA,
        ST_WDATA_X,
        ST_RDATA,
        ST_RD_NA,
        ST_IGNORE
    } sccb_state_t;

    // 8-bit ID byte the master sends for a write phase
    function automatic logic [7:0] sccb_wr_id(input logic [6:0] dev_id);
        return {dev_id, 1'b0};
    endfunction

    // 8-bit ID byte the master sends for a read phase
    function automatic logic [7:0] sccb_rd_id(input logic [6:0] dev_id);
        return {dev_id, 1'b1};
    endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronises SIOC/SIOD into the clk domain and derives bus conditions
// (START, STOP, SIOC rising/falling edge) from synchronised values only.
module sccb_line_sync #(
    parameter int unsigned SYNC_FF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sioc_in,
    input  logic siod_in,
    output logic start_det,
    output logic stop_det,
    output logic sioc_rise,
    output logic sioc_fall,
    output logic siod_s
);

    logic [SYNC_FF-1:0] r_sioc_sync;
    logic [SYNC_FF-1:0] r_siod_sync;
    logic               r_sioc_d;
    logic               r_siod_d;
    logic               w_sioc_s;

    // Synchroniser chains plus one history stage; reset to the idle (pulled-up) level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sioc_sync <= '1;
            r_siod_sync <= '1;
            r_sioc_d    <= 1'b1;
            r_siod_d    <= 1'b1;
        end else begin
            r_sioc_sync <= {r_sioc_sync[SYNC_FF-2:0], sioc_in};
            r_siod_sync <= {r_siod_sync[SYNC_FF-2:0], siod_in};
            r_sioc_d    <= r_sioc_sync[SYNC_FF-1];
            r_siod_d    <= r_siod_sync[SYNC_FF-1];
        end
    end

    assign w_sioc_s  = r_sioc_sync[SYNC_FF-1];
    assign siod_s    = r_siod_sync[SYNC_FF-1];
    assign sioc_rise = w_sioc_s & ~r_sioc_d;
    assign sioc_fall = ~w_sioc_s & r_sioc_d;
    assign start_det = w_sioc_s & r_sioc_d & r_siod_d & ~siod_s;
    assign stop_det  = w_sioc_s & r_sioc_d & ~r_siod_d & siod_s;

endmodule

// File: rtl/sccb_responder.sv
// SCCB target with a 256x8 register file. Decodes 3-phase writes and
// 2-phase-write + 2-phase-read sequences; reports each committed write.
// Optional build macro SCCB_RESP_ACK_EN: drive an I2C-style ACK on the 9th bit
// of matched ID, sub-address and write-data bytes.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0]  DEV_ID  = 7'h21,
    parameter int unsigned SYNC_FF = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sioc_in,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       id_err
);

    localparam logic [7:0] SCCB_WR_ID = sccb_wr_id(DEV_ID);
    localparam logic [7:0] SCCB_RD_ID = sccb_rd_id(DEV_ID);

    logic w_start_det, w_stop_det, w_sioc_rise, w_sioc_fall, w_siod_s;

    sccb_state_t          r_state, w_state_nxt;
    logic [BIT_CNT_W-1:0] r_bit_cnt, w_cnt_nxt;
    logic [7:0]           r_shift, w_shift_nxt;
    logic [7:0]           r_ptr, w_ptr_nxt;
    logic                 r_oe, w_oe_nxt;
    logic                 r_wr_valid, r_id_err, w_id_err_nxt, w_commit;
    logic [7:0]           r_wr_addr, r_wr_data;
    logic [7:0]           r_regs [256];
    logic [7:0]           w_byte_in, w_ptr_inc, w_rd_cur, w_rd_nxt;
    logic                 w_id_wr, w_id_rd;

    sccb_line_sync #(
        .SYNC_FF(SYNC_FF)
    ) u_line_sync (
        .clk      (clk),
        .rst      (rst),
        .sioc_in  (sioc_in),
        .siod_in  (siod_in),
        .start_det(w_start_det),
        .stop_det (w_stop_det),
        .sioc_rise(w_sioc_rise),
        .sioc_fall(w_sioc_fall),
        .siod_s   (w_siod_s)
    );

    assign w_byte_in = {r_shift[6:0], w_siod_s};
    assign w_ptr_inc = r_ptr + 8'd1;
    assign w_rd_cur  = r_regs[r_ptr];
    assign w_rd_nxt  = r_regs[w_ptr_inc];
    assign w_id_wr   = (r_shift == SCCB_WR_ID);
    assign w_id_rd   = (r_shift == SCCB_RD_ID);

    // Next-state, shifter, pointer and SIOD drive; bus conditions override bit activity
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_ptr_nxt    = r_ptr;
        w_oe_nxt     = r_oe;
        w_commit     = 1'b0;
        w_id_err_nxt = 1'b0;
        if (w_start_det) begin
            w_state_nxt = ST_ID;
            w_cnt_nxt   = '0;
            w_oe_nxt    = 1'b0;
        end else if (w_stop_det) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_oe_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_ID, ST_SUB, ST_WDATA: begin
                    if (w_sioc_rise) begin
                        w_shift_nxt = w_byte_in;
                        w_cnt_nxt   = r_bit_cnt + BIT_CNT_W'(1);
                        if (r_bit_cnt == BIT_CNT_LAST) begin
                            w_cnt_nxt = '0;
                            case (r_state)
                                ST_ID:   w_state_nxt = ST_ID_X;
                                ST_SUB:  w_state_nxt = ST_SUB_X;
                                default: begin
                                    w_state_nxt = ST_WDATA_X;
                                    w_commit    = 1'b1;
                                    w_ptr_nxt   = w_ptr_inc;
                                end
                            endcase
                        end
                    end
                end
                // Counter marks the 9th-bit sample: 0 = first falling edge (starts the
                // 9th bit), 1 = sampled, so the next falling edge leaves the state.
                ST_ID_X, ST_SUB_X, ST_WDATA_X: begin
                    if (w_sioc_rise) begin
                        w_cnt_nxt = BIT_CNT_W'(1);
                    end else if (w_sioc_fall) begin
                        if (r_bit_cnt != '0) begin
                            w_oe_nxt  = 1'b0;
                            w_cnt_nxt = '0;
                            case (r_state)
                                ST_ID_X: begin
                                    if (w_id_wr) begin
                                        w_state_nxt = ST_SUB;
                                    end else if (w_id_rd) begin
                                        w_state_nxt = ST_RDATA;
                                        w_shift_nxt = w_rd_cur;
                                        w_oe_nxt    = ~w_rd_cur[7];
                                    end else begin
                                        w_state_nxt  = ST_IGNORE;
                                        w_id_err_nxt = 1'b1;
                                    end
                                end
                                ST_SUB_X: begin
                                    w_ptr_nxt   = r_shift;
                                    w_state_nxt = ST_WDATA;
                                end
                                default: w_state_nxt = ST_WDATA;
                            endcase
                        end
`ifdef SCCB_RESP_ACK_EN
                        else begin
                            w_oe_nxt = (r_state != ST_ID_X) || w_id_wr || w_id_rd;
                        end
`endif
                    end
                end
                // Counter 0 on a falling edge means the MSB was freshly loaded and
                // must be driven without shifting.
                ST_RDATA: begin
                    if (w_sioc_rise) begin
                        w_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                        if (r_bit_cnt == BIT_CNT_LAST) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_RD_NA;
                        end
                    end else if (w_sioc_fall) begin
                        if (r_bit_cnt == '0) begin
                            w_oe_nxt = ~r_shift[7];
                        end else begin
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                            w_oe_nxt    = ~r_shift[6];
                        end
                    end
                end
                ST_RD_NA: begin
                    if (w_sioc_fall) begin
                        w_oe_nxt = 1'b0;
                    end else if (w_sioc_rise) begin
                        if (w_siod_s) begin
                            w_state_nxt = ST_IGNORE;
                        end else begin
                            w_ptr_nxt   = w_ptr_inc;
                            w_shift_nxt = w_rd_nxt;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_RDATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state, pointer, shifter and pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_oe       <= 1'b0;
            r_wr_valid <= 1'b0;
            r_id_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_ptr      <= w_ptr_nxt;
            r_oe       <= w_oe_nxt;
            r_wr_valid <= w_commit;
            r_id_err   <= w_id_err_nxt;
        end
    end

    // Register file and committed-write report
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 256; i++) r_regs[i] <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_commit) begin
            r_regs[r_ptr] <= w_byte_in;
            r_wr_addr     <= r_ptr;
            r_wr_data     <= w_byte_in;
        end
    end

    assign siod_oe  = r_oe;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign id_err   = r_id_err;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: a bit-level SCCB master drives directed and random
// transactions; a byte-level register-file model supplies every expectation.
module tb_sccb_responder;

    localparam int H = 8;
    localparam int Q = 4;
`ifdef SCCB_RESP_ACK_EN
    localparam bit ACK_BUILD = 1'b1;
`else
    localparam bit ACK_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl, m_sda;
    logic       sioc_in, siod_in;
    logic       siod_oe, wr_valid, busy, id_err;
    logic [7:0] wr_addr, wr_data;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0]  mdl_mem [256];
    logic [7:0]  mdl_ptr;
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    int          id_err_seen = 0;
    int          id_err_exp  = 0;
    int          viol        = 0;
    logic        win         = 1'b0;
    logic [7:0]  hist        = '0;
    logic [7:0]  wq [4];

    always #5 clk = ~clk;

    assign sioc_in = m_scl;
    assign siod_in = m_sda & ~siod_oe;

    sccb_responder #(
        .DEV_ID (7'h21),
        .SYNC_FF(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sioc_in (sioc_in),
        .siod_in (siod_in),
        .siod_oe (siod_oe),
        .wr_valid(wr_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .id_err  (id_err)
    );

    // Event monitor: write reports, ID errors and SIOD drive outside allowed windows
    always @(negedge clk) begin
        hist <= {hist[6:0], win};
        if (wr_valid) got_q.push_back({wr_addr, wr_data});
        if (id_err) id_err_seen <= id_err_seen + 1;
        if (siod_oe && !win && hist == '0) viol <= viol + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wbit(input logic b);
        m_sda = b;  wait_clk(Q);
        m_scl = 1'b1; wait_clk(H);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic rbit(output logic b);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        b = siod_in;  wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(H);
    endtask

    task automatic wbyte(input logic [7:0] v, input bit match, input bit keep_open, input string tag);
        logic a;
        for (int i = 7; i >= 1; i--) wbit(v[i]);
        if (keep_open || (ACK_BUILD && match)) win = 1'b1;
        wbit(v[0]);
        rbit(a);
        if (!keep_open) win = 1'b0;
        check_eq({tag, "_ack"}, {31'b0, a}, (ACK_BUILD && match) ? 32'd0 : 32'd1);
    endtask

    task automatic rbyte(output logic [7:0] v, input logic na);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            v[i] = b;
        end
        if (na) win = 1'b0;
        m_sda = na; wait_clk(Q);
        check_eq("na_oe", {31'b0, siod_oe}, 32'd0);
        m_scl = 1'b1; wait_clk(H);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic check_writes();
        logic [15:0] g, e;
        wait_clk(2);
        check_eq("wr_count", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check_eq("wr_event", {16'b0, g}, {16'b0, e});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_write(input logic [7:0] sub, input int n, input int abort_bits);
        bus_start();
        wbyte(8'h42, 1'b1, 1'b0, "wid");
        wbyte(sub, 1'b1, 1'b0, "wsub");
        mdl_ptr = sub;
        for (int i = 0; i < n; i++) begin
            wbyte(wq[i], 1'b1, 1'b0, "wdat");
            mdl_mem[mdl_ptr] = wq[i];
            exp_q.push_back({mdl_ptr, wq[i]});
            mdl_ptr = mdl_ptr + 8'd1;
        end
        for (int i = 0; i < abort_bits; i++) wbit(1'($urandom()));
        bus_stop();
        check_eq("busy_after_stop", {31'b0, busy}, 32'd0);
        check_writes();
    endtask

    task automatic do_read(input bit set_ptr, input logic [7:0] sub, input bit rep, input int n);
        logic [7:0] v;
        if (set_ptr) begin
            bus_start();
            wbyte(8'h42, 1'b1, 1'b0, "wid");
            wbyte(sub, 1'b1, 1'b0, "wsub");
            mdl_ptr = sub;
            if (!rep) bus_stop();
        end
        bus_start();
        wbyte(8'h43, 1'b1, 1'b1, "rid");
        for (int i = 0; i < n; i++) begin
            rbyte(v, (i == n - 1));
            check_eq("rd_data", {24'b0, v}, {24'b0, mdl_mem[mdl_ptr]});
            if (i != n - 1) mdl_ptr = mdl_ptr + 8'd1;
        end
        bus_stop();
        check_eq("busy_after_stop", {31'b0, busy}, 32'd0);
        check_writes();
    endtask

    task automatic do_badid(input logic [7:0] idb);
        bus_start();
        wbyte(idb, 1'b0, 1'b0, "bid");
        wbyte(8'($urandom()), 1'b0, 1'b0, "bx");
        check_eq("busy_ignore", {31'b0, busy}, 32'd1);
        bus_stop();
        check_eq("busy_after_stop", {31'b0, busy}, 32'd0);
        id_err_exp++;
        check_eq("id_err_cnt", id_err_seen, id_err_exp);
        check_writes();
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
        mdl_ptr = 8'h00;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       b;
        logic [6:0] id7;
        int         kind, n;
        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
        mdl_reset();
        wait_clk(5);
        rst = 1'b0;
        wait_clk(4);
        check_eq("rst_oe",     {31'b0, siod_oe},  32'd0);
        check_eq("rst_wvalid", {31'b0, wr_valid}, 32'd0);
        check_eq("rst_busy",   {31'b0, busy},     32'd0);
        check_eq("rst_iderr",  {31'b0, id_err},   32'd0);
        check_eq("rst_waddr",  {24'b0, wr_addr},  32'd0);
        check_eq("rst_wdata",  {24'b0, wr_data},  32'd0);

        wq[0] = 8'h80; do_write(8'h12, 1, 0);
        wq[0] = 8'hD0; do_write(8'h40, 1, 0);
        do_read(1'b1, 8'h40, 1'b0, 1);
        do_read(1'b1, 8'h12, 1'b1, 1);
        do_badid(8'h60);
        wq[0] = 8'hAA; wq[1] = 8'h55; do_write(8'hFF, 2, 0);
        do_read(1'b1, 8'hFF, 1'b0, 2);
        wq[0] = 8'h5A; do_write(8'h50, 1, 0);
        do_write(8'h50, 0, 4);
        do_read(1'b0, 8'h00, 1'b0, 1);
        wq[0] = 8'h3C; do_write(8'h60, 1, 4);

        // Reset in the middle of a read while the responder is pulling SIOD low
        wq[0] = 8'h00; do_write(8'h33, 1, 0);
        bus_start();
        wbyte(8'h42, 1'b1, 1'b0, "wid");
        wbyte(8'h33, 1'b1, 1'b0, "wsub");
        bus_stop();
        bus_start();
        wbyte(8'h43, 1'b1, 1'b1, "rid");
        rbit(b); rbit(b); rbit(b);
        check_eq("oe_mid_read", {31'b0, siod_oe}, 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check_eq("oe_after_rst", {31'b0, siod_oe}, 32'd0);
        m_scl = 1'b1; m_sda = 1'b1; win = 1'b0;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);
        mdl_reset();
        check_eq("busy_after_rst", {31'b0, busy}, 32'd0);
        check_eq("waddr_after_rst", {24'b0, wr_addr}, 32'd0);
        do_read(1'b0, 8'h00, 1'b0, 1);
        do_read(1'b1, 8'h12, 1'b0, 1);

        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    n = $urandom_range(1, 3);
                    for (int i = 0; i < n; i++) wq[i] = 8'($urandom());
                    do_write(8'($urandom()), n,
                             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
                end
                1: do_read(1'b1, 8'($urandom()), 1'($urandom()), $urandom_range(1, 3));
                2: do_read(1'b0, 8'h00, 1'b0, $urandom_range(1, 2));
                default: begin
                    id7 = 7'($urandom());
                    if (id7 == 7'h21) id7 = 7'h20;
                    do_badid({id7, 1'($urandom())});
                end
            endcase
        end

        wait_clk(10);
        check_eq("oe_outside_window", viol, 0);
        check_eq("id_err_total", id_err_seen, id_err_exp);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
